// File: rtl/line_mem_arbiter_if.sv
// Cache-side and memory-side bus of the line memory arbiter.
// The arbiter takes the slave view; the environment (caches + pmem) takes the master view.
interface line_mem_arbiter_if #(
  parameter int BEAT_WIDTH = 64,
  parameter int NUM_BEATS  = 4
);
  localparam int LINE_WIDTH = BEAT_WIDTH * NUM_BEATS;

  logic                  i_read;
  logic [31:0]           i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [31:0]           d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [31:0]           pmem_addr;
  logic [BEAT_WIDTH-1:0] pmem_wdata;
  logic [BEAT_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache line transfers onto
// a single burst memory port, one beat per pmem_resp.
module line_mem_arbiter #(
  parameter int BEAT_WIDTH = 64,
  parameter int NUM_BEATS  = 4
) (
  input logic               clk,
  input logic               rst,
  line_mem_arbiter_if.slave bus
);
  localparam int               LINE_WIDTH = BEAT_WIDTH * NUM_BEATS;
  localparam int               CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NUM_BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~32'h0000_001F;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  owner_e                grant;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [31:0]           addr_q, addr_d;
  logic                  i_pend, d_pend;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  // On a tie the client that was not granted last time wins.
  assign grant = (i_pend && d_pend) ? ((last_q == OWN_I) ? OWN_D : OWN_I)
               : (d_pend ? OWN_D : OWN_I);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      beat_q    <= '0;
      addr_q    <= '0;
      // NOTE: the line buffers are plain flops, so resetting them is cheap and
      // guarantees the rdata outputs read zero after reset.
      line_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every next-state variable defaults to its current value first,
    // so no path through the case statement can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    line_d    = line_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          owner_d = grant;
          last_d  = grant;
          if (grant == OWN_I) begin
            addr_d  = bus.i_addr & ALIGN_MASK;
            state_d = RD_BURST;
          end else begin
            addr_d = bus.d_addr & ALIGN_MASK;
            // Write wins over read when the D-cache raises both.
            if (bus.d_write) begin
              line_d  = bus.d_wdata;
              state_d = WR_BURST;
            end else begin
              state_d = RD_BURST;
            end
          end
        end
      end

      RD_BURST, WR_BURST: begin
        if (bus.pmem_resp) begin
          if (state_q == RD_BURST) begin
            line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.pmem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
            // Publish the assembled line together with its final beat so the
            // data is already valid in the resp cycle.
            if (state_q == RD_BURST) begin
              if (owner_q == OWN_I) i_rdata_d = line_d;
              else                  d_rdata_d = line_d;
            end
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_read  = (state_q == RD_BURST);
  assign bus.pmem_write = (state_q == WR_BURST);
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = (state_q == WR_BURST) ? line_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH]
                                                : '0;
  assign bus.i_resp     = (state_q == DONE) && (owner_q == OWN_I);
  assign bus.d_resp     = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: each task drives one scenario and
// compares the DUT against hand-computed values.
module tb_line_mem_arbiter;
  localparam int BW = 64;
  localparam int NB = 4;

  logic clk;
  logic rst;

  line_mem_arbiter_if #(.BEAT_WIDTH(BW), .NUM_BEATS(NB)) bus ();

  line_mem_arbiter #(.BEAT_WIDTH(BW), .NUM_BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations gathered by the memory responder during one burst.
  logic [63:0] mem_beats [4];
  logic [63:0] wdata_obs [4];
  int          strobe_cycles;
  bit          rd_seen, wr_seen, addr_bad, wdata_unstable, resp_seen;
  logic [31:0] addr_first;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of a burst; returns in the cycle after the 4th resp.
  task automatic serve_burst(input int stall);
    strobe_cycles  = 0;
    rd_seen        = 0;
    wr_seen        = 0;
    addr_bad       = 0;
    wdata_unstable = 0;
    resp_seen      = 0;
    addr_first     = bus.pmem_addr;
    for (int k = 0; k < 4; k++) begin
      logic [63:0] w_first;
      w_first = bus.pmem_wdata;
      for (int s = 0; s <= stall; s++) begin
        if (bus.pmem_read || bus.pmem_write) strobe_cycles++;
        if (bus.pmem_read)  rd_seen = 1;
        if (bus.pmem_write) wr_seen = 1;
        if (bus.pmem_addr !== addr_first) addr_bad = 1;
        if (bus.i_resp || bus.d_resp) resp_seen = 1;
        if (bus.pmem_wdata !== w_first) wdata_unstable = 1;
        if (s == stall) begin
          wdata_obs[k]   = bus.pmem_wdata;
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_beats[k];
        end else begin
          bus.pmem_resp  = 1'b0;
          bus.pmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        end
        tick;
      end
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  task automatic test_reset;
    total++; if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}); end
    total++; if (bus.pmem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.pmem_addr); end
    total++; if (bus.pmem_wdata !== 64'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus.pmem_wdata); end
    total++; if (bus.i_rdata !== 256'h0) begin bad++; $display("FAIL reset_irdata: got %h want 0", bus.i_rdata); end
    total++; if (bus.d_rdata !== 256'h0) begin bad++; $display("FAIL reset_drdata: got %h want 0", bus.d_rdata); end
  endtask

  task automatic test_i_read;
    logic [255:0] exp;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_1234;
    tick;
    total++; if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL iread_strobe_c1: got %b want 1", bus.pmem_read); end
    total++; if (bus.pmem_addr !== 32'h0000_1220) begin bad++; $display("FAIL iread_addr: got %h want 00001220", bus.pmem_addr); end
    mem_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    serve_burst(0);
    total++; if (strobe_cycles !== 4) begin bad++; $display("FAIL iread_strobe_cycles: got %0d want 4", strobe_cycles); end
    total++; if (addr_bad !== 1'b0) begin bad++; $display("FAIL iread_addr_stable: got %b want 0", addr_bad); end
    total++; if (resp_seen !== 1'b0) begin bad++; $display("FAIL iread_early_resp: got %b want 0", resp_seen); end
    total++; if (bus.i_resp !== 1'b1) begin bad++; $display("FAIL iread_iresp_c5: got %b want 1", bus.i_resp); end
    total++; if (bus.d_resp !== 1'b0) begin bad++; $display("FAIL iread_dresp: got %b want 0", bus.d_resp); end
    total++; if (bus.pmem_read !== 1'b0) begin bad++; $display("FAIL iread_strobe_done: got %b want 0", bus.pmem_read); end
    total++; if (bus.i_rdata !== exp) begin bad++; $display("FAIL iread_rdata: got %h want %h", bus.i_rdata, exp); end
    bus.i_read = 1'b0;
    tick;
    total++; if (bus.i_resp !== 1'b0) begin bad++; $display("FAIL iread_resp_one_cycle: got %b want 0", bus.i_resp); end
    total++; if (bus.i_rdata !== exp) begin bad++; $display("FAIL iread_rdata_hold: got %h want %h", bus.i_rdata, exp); end
  endtask

  // last_grant is I here, so D must win the tie; I changes address while waiting.
  task automatic test_tie_d_first;
    logic [255:0] exp_d, exp_i;
    exp_d = {64'h0000_0000_0000_D003, 64'h0000_0000_0000_D002,
             64'h0000_0000_0000_D001, 64'h0000_0000_0000_D000};
    exp_i = {64'h0000_0000_0000_E003, 64'h0000_0000_0000_E002,
             64'h0000_0000_0000_E001, 64'h0000_0000_0000_E000};
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_5008;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_6010;
    tick;
    total++; if (bus.pmem_addr !== 32'h0000_6000) begin bad++; $display("FAIL tie1_d_first_addr: got %h want 00006000", bus.pmem_addr); end
    bus.i_addr = 32'h0000_7FFC;
    mem_beats = '{64'h0000_0000_0000_D000, 64'h0000_0000_0000_D001,
                  64'h0000_0000_0000_D002, 64'h0000_0000_0000_D003};
    serve_burst(0);
    total++; if ({bus.d_resp, bus.i_resp} !== 2'b10) begin bad++; $display("FAIL tie1_d_resp: got %b want 10", {bus.d_resp, bus.i_resp}); end
    total++; if (bus.d_rdata !== exp_d) begin bad++; $display("FAIL tie1_d_rdata: got %h want %h", bus.d_rdata, exp_d); end
    bus.d_read = 1'b0;
    tick;
    tick;
    total++; if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL tie1_i_grant_gap: got %b want 1", bus.pmem_read); end
    total++; if (bus.pmem_addr !== 32'h0000_7FE0) begin bad++; $display("FAIL tie1_i_new_addr: got %h want 00007fe0", bus.pmem_addr); end
    mem_beats = '{64'h0000_0000_0000_E000, 64'h0000_0000_0000_E001,
                  64'h0000_0000_0000_E002, 64'h0000_0000_0000_E003};
    serve_burst(0);
    total++; if ({bus.d_resp, bus.i_resp} !== 2'b01) begin bad++; $display("FAIL tie1_i_resp: got %b want 01", {bus.d_resp, bus.i_resp}); end
    total++; if (bus.i_rdata !== exp_i) begin bad++; $display("FAIL tie1_i_rdata: got %h want %h", bus.i_rdata, exp_i); end
    total++; if (bus.d_rdata !== exp_d) begin bad++; $display("FAIL tie1_d_rdata_hold: got %h want %h", bus.d_rdata, exp_d); end
    bus.i_read = 1'b0;
    tick;
  endtask

  task automatic test_d_write;
    logic [255:0] exp_d;
    exp_d = {64'h0000_0000_0000_D003, 64'h0000_0000_0000_D002,
             64'h0000_0000_0000_D001, 64'h0000_0000_0000_D000};
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h8000_0040;
    bus.d_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
    tick;
    total++; if (bus.pmem_write !== 1'b1) begin bad++; $display("FAIL dwr_strobe: got %b want 1", bus.pmem_write); end
    total++; if (bus.pmem_wdata !== 64'hA) begin bad++; $display("FAIL dwr_beat0_first: got %h want a", bus.pmem_wdata); end
    total++; if (bus.pmem_addr !== 32'h8000_0040) begin bad++; $display("FAIL dwr_addr: got %h want 80000040", bus.pmem_addr); end
    mem_beats = '{64'h0, 64'h0, 64'h0, 64'h0};
    serve_burst(2);
    for (int k = 0; k < 4; k++) begin
      logic [63:0] w_exp;
      w_exp = 64'(k + 10);
      total++; if (wdata_obs[k] !== w_exp) begin bad++; $display("FAIL dwr_beat%0d: got %h want %h", k, wdata_obs[k], w_exp); end
    end
    total++; if (wdata_unstable !== 1'b0) begin bad++; $display("FAIL dwr_wdata_stable: got %b want 0", wdata_unstable); end
    total++; if (strobe_cycles !== 12) begin bad++; $display("FAIL dwr_strobe_cycles: got %0d want 12", strobe_cycles); end
    total++; if (rd_seen !== 1'b0) begin bad++; $display("FAIL dwr_no_read: got %b want 0", rd_seen); end
    total++; if ({bus.d_resp, bus.i_resp, bus.pmem_write} !== 3'b100) begin bad++; $display("FAIL dwr_done: got %b want 100", {bus.d_resp, bus.i_resp, bus.pmem_write}); end
    total++; if (bus.d_rdata !== exp_d) begin bad++; $display("FAIL dwr_rdata_unchanged: got %h want %h", bus.d_rdata, exp_d); end
    bus.d_write = 1'b0;
    tick;
  endtask

  // last_grant is D after the write, so I must win this tie.
  task automatic test_tie_i_first;
    logic [255:0] exp_i, exp_d;
    exp_i = {64'h0000_0000_0000_9A03, 64'h0000_0000_0000_9A02,
             64'h0000_0000_0000_9A01, 64'h0000_0000_0000_9A00};
    exp_d = {64'h0000_0000_0000_AD03, 64'h0000_0000_0000_AD02,
             64'h0000_0000_0000_AD01, 64'h0000_0000_0000_AD00};
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_9000;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_A020;
    tick;
    total++; if (bus.pmem_addr !== 32'h0000_9000) begin bad++; $display("FAIL tie2_i_first_addr: got %h want 00009000", bus.pmem_addr); end
    mem_beats = '{64'h0000_0000_0000_9A00, 64'h0000_0000_0000_9A01,
                  64'h0000_0000_0000_9A02, 64'h0000_0000_0000_9A03};
    serve_burst(1);
    total++; if ({bus.i_resp, bus.d_resp} !== 2'b10) begin bad++; $display("FAIL tie2_i_resp: got %b want 10", {bus.i_resp, bus.d_resp}); end
    total++; if (bus.i_rdata !== exp_i) begin bad++; $display("FAIL tie2_i_rdata: got %h want %h", bus.i_rdata, exp_i); end
    bus.i_read = 1'b0;
    tick;
    tick;
    total++; if (bus.pmem_addr !== 32'h0000_A020) begin bad++; $display("FAIL tie2_d_addr: got %h want 0000a020", bus.pmem_addr); end
    mem_beats = '{64'h0000_0000_0000_AD00, 64'h0000_0000_0000_AD01,
                  64'h0000_0000_0000_AD02, 64'h0000_0000_0000_AD03};
    serve_burst(0);
    total++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin bad++; $display("FAIL tie2_d_resp: got %b want 01", {bus.i_resp, bus.d_resp}); end
    total++; if (bus.d_rdata !== exp_d) begin bad++; $display("FAIL tie2_d_rdata: got %h want %h", bus.d_rdata, exp_d); end
    bus.d_read = 1'b0;
    tick;
  endtask

  task automatic test_rw_both;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_0C1F;
    bus.d_wdata = {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000};
    tick;
    total++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin bad++; $display("FAIL rw_write_wins: got %b want 10", {bus.pmem_write, bus.pmem_read}); end
    total++; if (bus.pmem_addr !== 32'h0000_0C00) begin bad++; $display("FAIL rw_addr: got %h want 00000c00", bus.pmem_addr); end
    serve_burst(1);
    total++; if (rd_seen !== 1'b0) begin bad++; $display("FAIL rw_no_read: got %b want 0", rd_seen); end
    total++; if (wdata_obs[3] !== 64'h5555_0003) begin bad++; $display("FAIL rw_beat3: got %h want 0000000055550003", wdata_obs[3]); end
    total++; if (bus.d_resp !== 1'b1) begin bad++; $display("FAIL rw_dresp: got %b want 1", bus.d_resp); end
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    logic [255:0] exp;
    exp = {64'h2000_0000_0000_0003, 64'h2000_0000_0000_0002,
           64'h2000_0000_0000_0001, 64'h2000_0000_0000_0000};
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_3000;
    tick;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'hBAD0_0000_0000_0000;
    tick;
    bus.pmem_rdata = 64'hBAD0_0000_0000_0001;
    tick;
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}); end
    total++; if (bus.pmem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr: got %h want 0", bus.pmem_addr); end
    total++; if ({bus.i_rdata, bus.d_rdata} !== 512'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", {bus.i_rdata, bus.d_rdata}); end
    tick;
    total++; if (bus.i_resp !== 1'b0) begin bad++; $display("FAIL midrst_no_resp: got %b want 0", bus.i_resp); end
    #2 rst = 1'b1;
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_2000;
    tick;
    total++; if ({bus.pmem_read, bus.pmem_addr} !== {1'b1, 32'h0000_2000}) begin
      bad++; $display("FAIL midrst_regrant: got %b/%h want 1/00002000", bus.pmem_read, bus.pmem_addr); end
    mem_beats = '{64'h2000_0000_0000_0000, 64'h2000_0000_0000_0001,
                  64'h2000_0000_0000_0002, 64'h2000_0000_0000_0003};
    serve_burst(0);
    total++; if (bus.i_resp !== 1'b1) begin bad++; $display("FAIL midrst_iresp: got %b want 1", bus.i_resp); end
    total++; if (bus.i_rdata !== exp) begin bad++; $display("FAIL midrst_rdata_order: got %h want %h", bus.i_rdata, exp); end
    bus.i_read = 1'b0;
    tick;
  endtask

  task automatic test_spurious_resp;
    logic [255:0] exp;
    exp = {64'h0100_0000_0000_0003, 64'h0100_0000_0000_0002,
           64'h0100_0000_0000_0001, 64'h0100_0000_0000_0000};
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    tick;
    total++; if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      bad++; $display("FAIL spur_idle: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}); end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0100;
    tick;
    total++; if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL spur_grant: got %b want 1", bus.pmem_read); end
    mem_beats = '{64'h0100_0000_0000_0000, 64'h0100_0000_0000_0001,
                  64'h0100_0000_0000_0002, 64'h0100_0000_0000_0003};
    serve_burst(1);
    total++; if (bus.d_resp !== 1'b1) begin bad++; $display("FAIL spur_dresp: got %b want 1", bus.d_resp); end
    total++; if (bus.d_rdata !== exp) begin bad++; $display("FAIL spur_rdata_order: got %h want %h", bus.d_rdata, exp); end
    bus.d_read = 1'b0;
    tick;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_read     = 1'b0;
    bus.i_addr     = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
    #1 rst = 1'b0;
    #1 test_reset();
    #10 rst = 1'b1;
    tick;
    test_i_read();
    test_tie_d_first();
    test_d_write();
    test_tie_i_first();
    test_rw_both();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
